word_block_packer: RTL and testbench
====================================

WORD_BLOCK_PACKER -- requirements
Module: word_block_packer

Interface
REQ-001 Parameter: WSIZE, default 32, input word width in bits (>=1).
REQ-002 Parameter: NWORDS, default 4, words per block (power of two, 2..16); block width BSIZE = WSIZE*NWORDS.
REQ-003 Parameter: FIRST_WORD_MSB, default 1; 1 = first-arriving word occupies out_data MSBs, 0 = occupies LSBs.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_data  input  WSIZE  word to pack.
REQ-007 in_valid  input  1  in_data valid this cycle.
REQ-008 in_last  input  1  qualifies in_data; this word closes the current block (partial if short).
REQ-009 in_ready  output  1  packer accepts a word this cycle.
REQ-010 flush  input  1  single-cycle request to close a partial block without a new word.
REQ-011 out_data  output  BSIZE  packed block.
REQ-012 out_mask  output  NWORDS  bit i = 1 when word of arrival index i is real data.
REQ-013 out_valid  output  1  out_data/out_mask valid.
REQ-014 out_ready  input  1  consumer takes block this cycle.
REQ-015 block_count  output  16  number of blocks transferred since reset.

Function
REQ-016 Word transfer occurs on a rising edge with in_valid && in_ready; block transfer occurs on a rising edge with out_valid && out_ready.
REQ-017 Storage: one assembly buffer (NWORDS words, fill count 0..NWORDS-1) plus one output register; state machine FILL / HOLD.
REQ-018 FILL: in_ready = 1; accepted word written to arrival index = count; count increments.
REQ-019 Block closes when accepted word has index NWORDS-1, or in_last = 1 with the word, or flush = 1 in FILL with count > 0 and no word accepted that cycle.
REQ-020 Closed block moves to output register on the closing edge when output register is empty or being drained that same edge; count returns to 0, state stays FILL.
REQ-021 Otherwise closed block stays in assembly buffer, state -> HOLD; HOLD: in_ready = 0, flush ignored.
REQ-022 HOLD -> FILL on the edge where output register is empty or being drained; block moves to output register, count = 0.
REQ-023 Unfilled word slots SHALL read zero in out_data and 0 in out_mask; full block mask = all ones.
REQ-024 Word placement: FIRST_WORD_MSB=1 -> index i at bits [BSIZE-1-i*WSIZE -: WSIZE]; 0 -> bits [i*WSIZE +: WSIZE]; out_mask bit order independent of this parameter.
REQ-025 flush with count = 0 and no word accepted SHALL have no effect (no empty block emitted).
REQ-026 flush coinciding with an accepted word SHALL close the block including that word.
REQ-027 out_data/out_mask SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-028 Sustained throughput with out_ready = 1: one word per clock, zero bubbles; input-to-output latency 1 clock after closing word.
REQ-029 block_count increments by 1 per block transfer, wraps 0xFFFF -> 0x0000.
REQ-030 in_valid = 0 SHALL leave buffer contents and count unchanged; in_last/in_data ignored.

Reset
REQ-031 reset asserted SHALL immediately force: state FILL, count 0, out_valid 0, out_data 0, out_mask 0, block_count 0, in_ready 1 after deassertion.
REQ-032 reset mid-block SHALL discard partial and held blocks; no block emitted after release.
REQ-033 First edge after reset deassertion SHALL accept a word if in_valid = 1.

Verification
REQ-034 Defaults, out_ready = 1, words 0x11,0x22,0x33,0x44 on 4 consecutive clocks -> next cycle out_valid = 1, out_data = 0x00000011_00000022_00000033_00000044, out_mask = 4'b1111, block_count = 1.
REQ-035 Words 0xA,0xB with in_last on 0xB -> out_data = 0x0000000A_0000000B_00000000_00000000, out_mask = 4'b0011; then flush with count 0 -> no block.
REQ-036 out_ready = 0, 8 words offered -> first block in output register, second in HOLD, in_ready = 0 after 8th word; raise out_ready -> both blocks in order, no word lost/duplicated.
REQ-037 FIRST_WORD_MSB = 0, NWORDS = 2, words 0x1,0x2 -> out_data = 0x00000002_00000001.
REQ-038 Assert reset after 3 words accepted -> out_valid = 0, count 0; next 4 words form clean block, mask 4'b1111.
REQ-039 65536 full blocks with out_ready = 1 -> block_count wraps to 0x0000, continuous 1 word/clock throughput.

Source files
------------

// File: rtl/word_block_packer_if.sv
// Handshake bundle between a word producer, the packer and a block consumer.
interface word_block_packer_if #(
  parameter int WSIZE  = 32,
  parameter int NWORDS = 4
);
  logic [WSIZE-1:0]        in_data;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic                    flush;
  logic [WSIZE*NWORDS-1:0] out_data;
  logic [NWORDS-1:0]       out_mask;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  in_data, in_valid, in_last, flush, out_ready,
    output in_ready, out_data, out_mask, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, flush, out_ready,
    input  in_ready, out_data, out_mask, out_valid
  );
endinterface

// File: rtl/word_block_packer.sv
// Packs WSIZE-bit words into NWORDS-word blocks with a per-word valid mask;
// one assembly buffer plus one output register, FILL/HOLD control.
module word_block_packer #(
  parameter int WSIZE          = 32,
  parameter int NWORDS         = 4,
  parameter bit FIRST_WORD_MSB = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  word_block_packer_if.slave  bus,
  output logic [15:0]         block_count
);

  localparam int BSIZE = WSIZE * NWORDS;
  localparam int IW    = $clog2(NWORDS);
  localparam int CW    = IW + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WSIZE-1:0] asm_q [NWORDS];
  logic [WSIZE-1:0] asm_d [NWORDS];
  logic [BSIZE-1:0] out_data_q, out_data_d;
  logic [NWORDS-1:0] out_mask_q, out_mask_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      block_count_q, block_count_d;

  logic             accept;
  logic             out_free;
  logic             close;
  logic [CW-1:0]    close_count;
  logic [CW-1:0]    pack_count;
  logic [WSIZE-1:0] asm_wr [NWORDS];
  logic [BSIZE-1:0] packed_data;
  logic [NWORDS-1:0] packed_mask;

  assign accept      = (state_q == ST_FILL) && bus.in_valid;
  assign out_free    = !out_valid_q || bus.out_ready;
  assign close_count = count_q + CW'(accept);
  assign close       = (state_q == ST_FILL) &&
                       ((accept && ((count_q == LAST_IDX) || bus.in_last || bus.flush)) ||
                        (!accept && bus.flush && (count_q != '0)));
  // A held block already carries its final word count in count_q.
  assign pack_count  = (state_q == ST_HOLD) ? count_q : close_count;

  always_comb begin
    for (int i = 0; i < NWORDS; i++) begin
      asm_wr[i] = asm_q[i];
    end
    if (accept) begin
      asm_wr[count_q[IW-1:0]] = bus.in_data;
    end
  end

  // Slots beyond pack_count are forced to zero, so stale buffer words never leak out.
  always_comb begin
    packed_data = '0;
    packed_mask = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (CW'(i) < pack_count) begin
        packed_mask[i] = 1'b1;
        if (FIRST_WORD_MSB) begin
          packed_data[BSIZE-1-i*WSIZE -: WSIZE] = asm_wr[i];
        end else begin
          packed_data[i*WSIZE +: WSIZE] = asm_wr[i];
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    asm_d         = asm_q;
    out_data_d    = out_data_q;
    out_mask_d    = out_mask_q;
    out_valid_d   = out_valid_q && !bus.out_ready;
    block_count_d = block_count_q + 16'(out_valid_q && bus.out_ready);

    if (state_q == ST_FILL) begin
      asm_d   = asm_wr;
      count_d = close_count;
      if (close) begin
        if (out_free) begin
          out_data_d  = packed_data;
          out_mask_d  = packed_mask;
          out_valid_d = 1'b1;
          count_d     = '0;
        end else begin
          state_d = ST_HOLD;
        end
      end
    end else if (out_free) begin
      out_data_d  = packed_data;
      out_mask_d  = packed_mask;
      out_valid_d = 1'b1;
      count_d     = '0;
      state_d     = ST_FILL;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_FILL;
      count_q       <= '0;
      out_data_q    <= '0;
      out_mask_q    <= '0;
      out_valid_q   <= 1'b0;
      block_count_q <= '0;
      for (int i = 0; i < NWORDS; i++) begin
        asm_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      out_data_q    <= out_data_d;
      out_mask_q    <= out_mask_d;
      out_valid_q   <= out_valid_d;
      block_count_q <= block_count_d;
      for (int i = 0; i < NWORDS; i++) begin
        asm_q[i] <= asm_d[i];
      end
    end
  end

  assign bus.in_ready  = (state_q == ST_FILL);
  assign bus.out_data  = out_data_q;
  assign bus.out_mask  = out_mask_q;
  assign bus.out_valid = out_valid_q;
  assign block_count   = block_count_q;

endmodule

// File: tb/tb_word_block_packer.sv
// Bench for word_block_packer: vector table, hand sequences, randomized
// traffic against a queue-based block model, and a block_count wrap run.
module tb_word_block_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] bc1, bc2;
  int          total = 0;
  int          bad = 0;

  word_block_packer_if #(.WSIZE(32), .NWORDS(4)) bus1 ();
  word_block_packer_if #(.WSIZE(32), .NWORDS(2)) bus2 ();

  word_block_packer #(.WSIZE(32), .NWORDS(4), .FIRST_WORD_MSB(1'b1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1), .block_count(bc1)
  );

  word_block_packer #(.WSIZE(32), .NWORDS(2), .FIRST_WORD_MSB(1'b0)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2), .block_count(bc2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v, l, f, r;
    logic [31:0] d;
    logic        exp_valid, exp_ready;
    logic [127:0] exp_data;
    logic [3:0]  exp_mask;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs[21];

  localparam logic [127:0] B1 = 128'h00000011_00000022_00000033_00000044;
  localparam logic [127:0] B2 = 128'h0000000A_0000000B_00000000_00000000;
  localparam logic [127:0] B3 = 128'h00000001_00000002_00000003_00000004;
  localparam logic [127:0] B4 = 128'h00000005_00000006_00000007_00000008;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic l, input logic f, input logic r,
                                input logic [31:0] d);
    bus1.in_valid  = v;
    bus1.in_last   = l;
    bus1.flush     = f;
    bus1.out_ready = r;
    bus1.in_data   = d;
  endtask

  function automatic vec_t mk(input logic v, input logic l, input logic f, input logic r,
                              input logic [31:0] d, input logic ev, input logic er,
                              input logic [127:0] ed, input logic [3:0] em, input logic [15:0] ec);
    vec_t t;
    t.v = v; t.l = l; t.f = f; t.r = r; t.d = d;
    t.exp_valid = ev; t.exp_ready = er; t.exp_data = ed; t.exp_mask = em; t.exp_count = ec;
    return t;
  endfunction

  task automatic do_reset();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Reference: closed-but-untransferred blocks live in a FIFO; at most two
  // (output register plus held block) may exist before input is refused.
  logic [31:0]  cur[$];
  logic [127:0] exp_data_q[$];
  logic [3:0]   exp_mask_q[$];
  logic [15:0]  model_bc;

  task automatic model_close();
    logic [127:0] data = '0;
    logic [3:0]   mask = '0;
    for (int i = 0; i < cur.size(); i++) begin
      data = data | (128'(cur[i]) << (32 * (3 - i)));
      mask[i] = 1'b1;
    end
    exp_data_q.push_back(data);
    exp_mask_q.push_back(mask);
    cur.delete();
  endtask

  initial begin
    logic v, l, f, r, ready, xfer, closed;
    logic [31:0] d;
    int bubbles;

    bus2.in_valid = 1'b0; bus2.in_last = 1'b0; bus2.flush = 1'b0;
    bus2.out_ready = 1'b1; bus2.in_data = '0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    #12;
    check_output("reset.out_valid", 128'(bus1.out_valid), 128'(1'b0));
    check_output("reset.out_data", bus1.out_data, 128'h0);
    check_output("reset.out_mask", 128'(bus1.out_mask), 128'h0);
    check_output("reset.block_count", 128'(bc1), 128'h0);
    check_output("reset.in_ready", 128'(bus1.in_ready), 128'(1'b1));
    @(negedge clock);
    reset = 1'b0;

    vecs[0]  = mk(1, 0, 0, 1, 32'h11, 0, 1, '0, 4'h0, 16'd0);
    vecs[1]  = mk(1, 0, 0, 1, 32'h22, 0, 1, '0, 4'h0, 16'd0);
    vecs[2]  = mk(1, 0, 0, 1, 32'h33, 0, 1, '0, 4'h0, 16'd0);
    vecs[3]  = mk(1, 0, 0, 1, 32'h44, 1, 1, B1, 4'hF, 16'd0);
    vecs[4]  = mk(0, 0, 0, 1, 32'h0,  0, 1, '0, 4'h0, 16'd1);
    vecs[5]  = mk(1, 0, 0, 1, 32'hA,  0, 1, '0, 4'h0, 16'd1);
    vecs[6]  = mk(1, 1, 0, 1, 32'hB,  1, 1, B2, 4'h3, 16'd1);
    vecs[7]  = mk(0, 0, 1, 1, 32'h0,  0, 1, '0, 4'h0, 16'd2);
    vecs[8]  = mk(0, 0, 1, 1, 32'h0,  0, 1, '0, 4'h0, 16'd2);
    vecs[9]  = mk(0, 0, 0, 1, 32'h0,  0, 1, '0, 4'h0, 16'd2);
    vecs[10] = mk(1, 0, 0, 0, 32'h1,  0, 1, '0, 4'h0, 16'd2);
    vecs[11] = mk(1, 0, 0, 0, 32'h2,  0, 1, '0, 4'h0, 16'd2);
    vecs[12] = mk(1, 0, 0, 0, 32'h3,  0, 1, '0, 4'h0, 16'd2);
    vecs[13] = mk(1, 0, 0, 0, 32'h4,  1, 1, B3, 4'hF, 16'd2);
    vecs[14] = mk(1, 0, 0, 0, 32'h5,  1, 1, B3, 4'hF, 16'd2);
    vecs[15] = mk(1, 0, 0, 0, 32'h6,  1, 1, B3, 4'hF, 16'd2);
    vecs[16] = mk(1, 0, 0, 0, 32'h7,  1, 1, B3, 4'hF, 16'd2);
    vecs[17] = mk(1, 0, 0, 0, 32'h8,  1, 0, B3, 4'hF, 16'd2);
    vecs[18] = mk(1, 0, 1, 0, 32'h9,  1, 0, B3, 4'hF, 16'd2);
    vecs[19] = mk(0, 0, 0, 1, 32'h0,  1, 1, B4, 4'hF, 16'd3);
    vecs[20] = mk(0, 0, 0, 1, 32'h0,  0, 1, '0, 4'h0, 16'd4);

    for (int i = 0; i < 21; i++) begin
      apply_stimulus(vecs[i].v, vecs[i].l, vecs[i].f, vecs[i].r, vecs[i].d);
      @(posedge clock);
      @(negedge clock);
      check_output($sformatf("vec%0d.out_valid", i), 128'(bus1.out_valid), 128'(vecs[i].exp_valid));
      check_output($sformatf("vec%0d.in_ready", i), 128'(bus1.in_ready), 128'(vecs[i].exp_ready));
      check_output($sformatf("vec%0d.block_count", i), 128'(bc1), 128'(vecs[i].exp_count));
      if (vecs[i].exp_valid) begin
        check_output($sformatf("vec%0d.out_data", i), bus1.out_data, vecs[i].exp_data);
        check_output($sformatf("vec%0d.out_mask", i), 128'(bus1.out_mask), 128'(vecs[i].exp_mask));
      end
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

    // LSB-first placement on the two-word instance.
    bus2.in_valid = 1'b1; bus2.in_data = 32'h1;
    @(posedge clock); @(negedge clock);
    bus2.in_data = 32'h2;
    @(posedge clock); @(negedge clock);
    bus2.in_valid = 1'b0;
    check_output("lsb.out_valid", 128'(bus2.out_valid), 128'(1'b1));
    check_output("lsb.out_data", 128'(bus2.out_data), 128'h00000002_00000001);
    check_output("lsb.out_mask", 128'(bus2.out_mask), 128'h3);
    @(posedge clock); @(negedge clock);

    // Reset with a full output register and a 3-word partial block in flight.
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h20 + 32'(i));
      @(posedge clock); @(negedge clock);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    #2 reset = 1'b1;
    #1;
    check_output("midreset.out_valid", 128'(bus1.out_valid), 128'(1'b0));
    check_output("midreset.out_mask", 128'(bus1.out_mask), 128'h0);
    check_output("midreset.block_count", 128'(bc1), 128'h0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h5 + 32'(i));
      @(posedge clock); @(negedge clock);
      check_output($sformatf("postreset%0d.out_valid", i), 128'(bus1.out_valid), 128'(i == 3));
    end
    check_output("postreset.out_data", bus1.out_data, B4);
    check_output("postreset.out_mask", 128'(bus1.out_mask), 128'hF);

    // Randomized traffic against the block FIFO model.
    do_reset();
    cur.delete(); exp_data_q.delete(); exp_mask_q.delete();
    model_bc = '0;
    for (int c = 0; c < 2000; c++) begin
      check_output("rand.in_ready", 128'(bus1.in_ready), 128'(exp_data_q.size() < 2));
      check_output("rand.out_valid", 128'(bus1.out_valid), 128'(exp_data_q.size() > 0));
      check_output("rand.block_count", 128'(bc1), 128'(model_bc));
      if (exp_data_q.size() > 0) begin
        check_output("rand.out_data", bus1.out_data, exp_data_q[0]);
        check_output("rand.out_mask", 128'(bus1.out_mask), 128'(exp_mask_q[0]));
      end
      v = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 99) < 15);
      f = ($urandom_range(0, 99) < 10);
      r = ($urandom_range(0, 9) < 6);
      d = $urandom;
      apply_stimulus(v, l, f, r, d);
      @(posedge clock);
      ready  = (exp_data_q.size() < 2);
      xfer   = (exp_data_q.size() > 0) && r;
      closed = 1'b0;
      if (v && ready) begin
        cur.push_back(d);
        if (cur.size() == 4 || l || f) closed = 1'b1;
      end else if (f && ready && cur.size() > 0) begin
        closed = 1'b1;
      end
      if (xfer) begin
        void'(exp_data_q.pop_front());
        void'(exp_mask_q.pop_front());
        model_bc = model_bc + 16'd1;
      end
      if (closed) model_close();
      @(negedge clock);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

    // One single-word block per clock until block_count wraps.
    do_reset();
    bubbles = 0;
    bus2.in_valid = 1'b1; bus2.in_last = 1'b1; bus2.out_ready = 1'b1;
    for (int k = 0; k < 65536; k++) begin
      bus2.in_data = 32'(k);
      @(posedge clock); @(negedge clock);
      if (!bus2.out_valid || !bus2.in_ready) bubbles++;
    end
    check_output("wrap.bubbles", 128'(bubbles), 128'h0);
    check_output("wrap.count_ffff", 128'(bc2), 128'hFFFF);
    check_output("wrap.last_data", 128'(bus2.out_data), 128'h00000000_0000FFFF);
    check_output("wrap.last_mask", 128'(bus2.out_mask), 128'h1);
    bus2.in_valid = 1'b0; bus2.in_last = 1'b0;
    @(posedge clock); @(negedge clock);
    check_output("wrap.count_zero", 128'(bc2), 128'h0);
    check_output("wrap.out_valid", 128'(bus2.out_valid), 128'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
